cdb_arbiter: RTL and testbench

// - Shares one common data bus (CDB) between NUM_REQ functional-unit writeback requesters (add, mul, div, br).
// - Each requester gets a one-entry holding buffer. One buffered result is granted per cycle, round-robin,
//   and broadcast to the ROB commit-mark port, the RAT/PRF wakeup and the reservation stations.
// - Flush (branch mispredict) discards all results not yet broadcast.

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus between NUM_REQ writeback requesters.
// Each requester owns a one-entry holding buffer. One buffered result is granted
// per cycle in round-robin order and broadcast combinationally on the cdb_* outputs.
// A flush discards every result that has not been broadcast yet.
// Optional build macro CDB_BR_PRIORITY_EN: the branch unit (index NUM_REQ-1) is
// granted ahead of everyone else whenever its buffer is valid, without moving rr_ptr.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = 64,
  parameter int PHYS_W    = 6,
  parameter int DATA_W    = 32,
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH),
  localparam int RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
  input  logic [NUM_REQ*PHYS_W-1:0]      req_pd,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  output logic                           cdb_valid,
  output logic [NUM_REQ-1:0]             cdb_src,
  output logic [ROB_IDX_W-1:0]           cdb_rob_idx,
  output logic [PHYS_W-1:0]              cdb_pd,
  output logic [DATA_W-1:0]              cdb_data
);

  logic [NUM_REQ-1:0]           buf_valid_q, buf_valid_d;
  logic [NUM_REQ*ROB_IDX_W-1:0] buf_rob_q, buf_rob_d;
  logic [NUM_REQ*PHYS_W-1:0]    buf_pd_q, buf_pd_d;
  logic [NUM_REQ*DATA_W-1:0]    buf_data_q, buf_data_d;
  logic [RR_W-1:0]              rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] grant;
  logic [RR_W-1:0]    grant_idx;
  logic [RR_W-1:0]    scan_idx;
  logic               grant_found;
  logic               br_pri_grant;

  // Pick the buffer to broadcast: first valid one scanning from rr_ptr, branch first if prioritised.
  always_comb begin
    grant        = '0;
    grant_idx    = '0;
    scan_idx     = '0;
    grant_found  = 1'b0;
    br_pri_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = RR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && buf_valid_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
`ifdef CDB_BR_PRIORITY_EN
    if (buf_valid_q[NUM_REQ-1]) begin
      grant_found  = 1'b1;
      grant_idx    = RR_W'(NUM_REQ - 1);
      br_pri_grant = 1'b1;
    end
`else
    br_pri_grant = 1'b0;
`endif
    if (rst || flush) begin
      grant_found  = 1'b0;
      br_pri_grant = 1'b0;
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Drive the broadcast from the granted buffer; everything is zero when nothing is granted.
  always_comb begin
    cdb_valid   = grant_found;
    cdb_src     = grant;
    cdb_rob_idx = '0;
    cdb_pd      = '0;
    cdb_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        cdb_rob_idx = cdb_rob_idx | buf_rob_q[i*ROB_IDX_W +: ROB_IDX_W];
        cdb_pd      = cdb_pd      | buf_pd_q[i*PHYS_W +: PHYS_W];
        cdb_data    = cdb_data    | buf_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // A buffer can take a new result when empty or being drained this very cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && !flush && (!buf_valid_q[i] || grant[i]);
    end
  end

  // Next buffer contents and pointer: drain the granted buffer, latch accepted results, flush clears all.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rob_d   = buf_rob_q;
    buf_pd_d    = buf_pd_q;
    buf_data_d  = buf_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      buf_valid_d = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          buf_valid_d[i] = 1'b0;
        end
        if (req_valid[i] && req_ready[i]) begin
          buf_valid_d[i]                          = 1'b1;
          buf_rob_d[i*ROB_IDX_W +: ROB_IDX_W]     = req_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
          buf_pd_d[i*PHYS_W +: PHYS_W]            = req_pd[i*PHYS_W +: PHYS_W];
          buf_data_d[i*DATA_W +: DATA_W]          = req_data[i*DATA_W +: DATA_W];
        end
      end
      if (grant_found && !br_pri_grant) begin
        rr_ptr_d = RR_W'((int'(grant_idx) + 1) % NUM_REQ);
      end
    end
  end

  // State registers; reset drops every pending result and restarts the scan at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      buf_rob_q   <= '0;
      buf_pd_q    <= '0;
      buf_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rob_q   <= buf_rob_d;
      buf_pd_q    <= buf_pd_d;
      buf_data_q  <= buf_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of the CDB arbiter, one vector per clock cycle.
// Requester i is driven with payload rob=seed+i, pd=seed+16*i, data={i,16'hBEEF,seed}.
module tb_cdb_arbiter;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [23:0]  req_rob_idx;
  logic [23:0]  req_pd;
  logic [127:0] req_data;
  logic         cdb_valid;
  logic [3:0]   cdb_src;
  logic [5:0]   cdb_rob_idx;
  logic [5:0]   cdb_pd;
  logic [31:0]  cdb_data;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  vld;
    logic [7:0]  seed;
    logic        e_valid;
    logic [3:0]  e_src;
    logic [5:0]  e_rob;
    logic [5:0]  e_pd;
    logic [31:0] e_data;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t vecs[12];

  cdb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rob_idx (req_rob_idx),
    .req_pd      (req_pd),
    .req_data    (req_data),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_pd      (cdb_pd),
    .cdb_data    (cdb_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [3:0] v, input logic [7:0] seed);
    rst       = r;
    flush     = f;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_rob_idx[i*6 +: 6]  = 6'(int'(seed) + i);
      req_pd[i*6 +: 6]       = 6'(int'(seed) + 16 * i);
      req_data[i*32 +: 32]   = {8'(i), 16'hBEEF, seed};
    end
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input logic [3:0] e_src,
                             input logic [5:0] e_rob, input logic [5:0] e_pd,
                             input logic [31:0] e_data, input logic [3:0] e_ready);
    checks++;
    if (cdb_valid !== e_valid || cdb_src !== e_src || cdb_rob_idx !== e_rob ||
        cdb_pd !== e_pd || cdb_data !== e_data || req_ready !== e_ready) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%b src=%b rob=%h pd=%h data=%h ready=%b, expected valid=%b src=%b rob=%h pd=%h data=%h ready=%b",
               name, cdb_valid, cdb_src, cdb_rob_idx, cdb_pd, cdb_data, req_ready,
               e_valid, e_src, e_rob, e_pd, e_data, e_ready);
    end
  endtask

  // Sample at the falling edge, then move to just after the next rising edge.
  task automatic sampleAndStep(input string name, input logic e_valid, input logic [3:0] e_src,
                               input logic [5:0] e_rob, input logic [5:0] e_pd,
                               input logic [31:0] e_data, input logic [3:0] e_ready);
    @(negedge clk);
    checkOutput(name, e_valid, e_src, e_rob, e_pd, e_data, e_ready);
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, single result, round-robin table, flush, reset while full, branch priority.
  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0000_0000, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 4'b1111, 8'h10, 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0000_0000, 4'b1111};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 8'h20, 1'b1, 4'b0001, 6'h10, 6'h10, 32'h00BE_EF10, 4'b0001};
    vecs[3]  = '{1'b0, 1'b0, 4'b1111, 8'h30, 1'b1, 4'b0010, 6'h11, 6'h20, 32'h01BE_EF10, 4'b0010};
    vecs[4]  = '{1'b0, 1'b0, 4'b1111, 8'h04, 1'b1, 4'b0100, 6'h12, 6'h30, 32'h02BE_EF10, 4'b0100};
    vecs[5]  = '{1'b0, 1'b0, 4'b1111, 8'h08, 1'b1, 4'b1000, 6'h13, 6'h00, 32'h03BE_EF10, 4'b1000};
    vecs[6]  = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001, 6'h20, 6'h20, 32'h00BE_EF20, 4'b0001};
    vecs[7]  = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b0010, 6'h31, 6'h00, 32'h01BE_EF30, 4'b0011};
    vecs[8]  = '{1'b0, 1'b0, 4'b0001, 8'h3F, 1'b1, 4'b0100, 6'h06, 6'h24, 32'h02BE_EF04, 4'b0111};
    vecs[9]  = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b1000, 6'h0B, 6'h38, 32'h03BE_EF08, 4'b1110};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 4'b0001, 6'h3F, 6'h3F, 32'h00BE_EF3F, 4'b1111};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0000_0000, 4'b1111};

    applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
    @(posedge clk);
    #1;
    sampleAndStep("in_reset", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b0000);

    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("reset_idle", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);

    applyStimulus(1'b0, 1'b0, 4'b0001, 8'h00);
    req_rob_idx[5:0] = 6'd5;
    req_pd[5:0]      = 6'd12;
    req_data[31:0]   = 32'hDEAD_BEEF;
    sampleAndStep("single_accept", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("single_bcast", 1'b1, 4'b0001, 6'd5, 6'd12, 32'hDEAD_BEEF, 4'b1111);
    sampleAndStep("single_done", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);

`ifndef CDB_BR_PRIORITY_EN
    for (int n = 0; n < 12; n++) begin
      applyStimulus(vecs[n].rst, vecs[n].flush, vecs[n].vld, vecs[n].seed);
      sampleAndStep($sformatf("rr_vec%0d", n), vecs[n].e_valid, vecs[n].e_src, vecs[n].e_rob,
                    vecs[n].e_pd, vecs[n].e_data, vecs[n].e_ready);
    end
`else
    applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("pri_reset", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("pri_idle", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    sampleAndStep("pri_idle2", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
`endif

    applyStimulus(1'b0, 1'b0, 4'b0110, 8'h01);
    sampleAndStep("flush_fill", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b1, 4'b1111, 8'h02);
    sampleAndStep("flush_cycle", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("flush_after1", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    sampleAndStep("flush_after2", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0001, 8'h11);
    sampleAndStep("flush_newreq", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("flush_resume", 1'b1, 4'b0001, 6'h11, 6'h11, 32'h00BE_EF11, 4'b1111);

    applyStimulus(1'b0, 1'b0, 4'b1011, 8'h05);
    sampleAndStep("rstfull_fill", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("rstfull_rst", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0100, 8'h07);
    sampleAndStep("rstfull_release", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("rstfull_req2", 1'b1, 4'b0100, 6'h09, 6'h27, 32'h02BE_EF07, 4'b1111);
    sampleAndStep("rstfull_idle", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);

    applyStimulus(1'b1, 1'b0, 4'b0000, 8'h00);
    sampleAndStep("br_rst", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b1001, 8'h02);
    sampleAndStep("br_fill", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);
    applyStimulus(1'b0, 1'b0, 4'b0000, 8'h00);
`ifdef CDB_BR_PRIORITY_EN
    sampleAndStep("br_first", 1'b1, 4'b1000, 6'h05, 6'h32, 32'h03BE_EF02, 4'b1110);
    sampleAndStep("br_second", 1'b1, 4'b0001, 6'h02, 6'h02, 32'h00BE_EF02, 4'b1111);
`else
    sampleAndStep("br_first", 1'b1, 4'b0001, 6'h02, 6'h02, 32'h00BE_EF02, 4'b0111);
    sampleAndStep("br_second", 1'b1, 4'b1000, 6'h05, 6'h32, 32'h03BE_EF02, 4'b1111);
`endif
    sampleAndStep("br_idle", 1'b0, 4'b0000, 6'h00, 6'h00, 32'h0, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
